// File: rtl/thermo_dac_pkg.sv
// Shared definitions for the thermometer DAC driver: FSM state encoding,
// level-count derivation, binary-to-thermometer conversion and a modulo adder
// used by the data-weighted-averaging pointer.
package thermo_dac_pkg;

  localparam int MAX_NBITS = 6;
  localparam int MAX_NLEV  = (1 << MAX_NBITS) - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RAMP   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    RAMP   = ST_RAMP,
    SETTLE = ST_SETTLE
  } state_t;

  function automatic int nlev(input int nbits);
    return (1 << nbits) - 1;
  endfunction

  // Bit i is set when code > i; callers truncate to their own level count.
  function automatic logic [MAX_NLEV-1:0] bin2therm(input logic [MAX_NBITS-1:0] code);
    logic [MAX_NLEV-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_NLEV; i++) begin
      t[i] = (int'(code) > i);
    end
    return t;
  endfunction

  // (a + b) mod m, valid while a < m and b <= m, so one subtraction suffices.
  function automatic logic [MAX_NBITS-1:0] mod_add(input logic [MAX_NBITS-1:0] a,
                                                    input logic [MAX_NBITS-1:0] b,
                                                    input logic [MAX_NBITS:0]   m);
    logic [MAX_NBITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= m) begin
      s = s - m;
    end
    return s[MAX_NBITS-1:0];
  endfunction

endpackage

// File: rtl/thermo_dac_driver_rotator.sv
// Combinational rotate-left of a thermometer pattern by a pointer (< NLEV).
// With the pointer held at zero it is a pass-through.
module thermo_rotator
  import thermo_dac_pkg::*;
#(
  parameter int NLEV = 3
) (
  input  logic [NLEV-1:0]      din,
  input  logic [MAX_NBITS-1:0] ptr,
  output logic [NLEV-1:0]      dout
);

  // Shift a doubled copy so the bits pushed past the top wrap back to the bottom.
  always_comb begin
    dout = NLEV'(({din, din} << ptr) >> NLEV);
  end

endmodule

// File: rtl/thermo_dac_driver.sv
// Thermometer (unit-element) DAC driver. Accepts a binary target code, walks
// the driven level one step per clock toward it, holds for SETTLE_CYC cycles,
// then pulses done. Optional data-weighted averaging is enabled by defining
// THERMO_DAC_DWA_EN: the active elements are rotated by a pointer that advances
// by the settled level each time a conversion completes.
//
// state  | meaning
// IDLE   | waiting for a code, in_ready high
// RAMP   | cur_code stepping toward target
// SETTLE | holding target for SETTLE_CYC cycles
module thermo_dac_driver
  import thermo_dac_pkg::*;
#(
  parameter  int NBITS      = 2,
  parameter  int SETTLE_CYC = 2,
  localparam int NLEV       = (1 << NBITS) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_code,
  output logic [NLEV-1:0]  therm,
  output logic [NBITS-1:0] cur_code,
  output logic             busy,
  output logic             done
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

  state_t                 state;
  logic [NBITS-1:0]       target;
  logic [CW-1:0]          settle_cnt;
  logic [NBITS-1:0]       cur_nxt;
  logic                   enter_idle;
  logic [NLEV-1:0]        therm_base;
  logic [NLEV-1:0]        therm_nxt;
  logic [MAX_NBITS-1:0]   ptr_nxt;

  // Next driven level: one step toward target while ramping, otherwise hold.
  always_comb begin
    cur_nxt    = cur_code;
    enter_idle = 1'b0;
    if (state == RAMP) begin
      cur_nxt = (cur_code < target) ? cur_code + NBITS'(1) : cur_code - NBITS'(1);
    end
    if ((state == SETTLE) && (settle_cnt == '0)) begin
      enter_idle = 1'b1;
    end
  end

  // Plain thermometer pattern for the next level, before any rotation.
  always_comb begin
    therm_base = NLEV'(bin2therm(MAX_NBITS'(cur_nxt)));
  end

`ifdef THERMO_DAC_DWA_EN
  localparam logic [MAX_NBITS:0] NLEV_M = (MAX_NBITS + 1)'(NLEV);

  logic [MAX_NBITS-1:0] ptr;

  // Pointer advances by the settled level as the conversion completes, so the
  // rotated pattern shows up in the same cycle as done.
  always_comb begin
    ptr_nxt = enter_idle ? mod_add(ptr, MAX_NBITS'(cur_code), NLEV_M) : ptr;
  end

  // DWA pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end
`else
  // Without DWA the rotator sees a zero pointer and passes the pattern through.
  always_comb begin
    ptr_nxt = '0;
  end
`endif

  thermo_rotator #(
    .NLEV (NLEV)
  ) u_rotator (
    .din  (therm_base),
    .ptr  (ptr_nxt),
    .dout (therm_nxt)
  );

  // Sequencing FSM with registered level, switch drive and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      target     <= '0;
      settle_cnt <= '0;
      cur_code   <= '0;
      therm      <= '0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      cur_code <= cur_nxt;
      therm    <= therm_nxt;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            target   <= in_code;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (in_code != cur_code) begin
              state <= RAMP;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end
        end
        RAMP: begin
          if (cur_nxt == target) begin
            state      <= SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          if (enter_idle) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thermo_dac_driver.sv
// Self-checking bench for thermo_dac_driver (NBITS=2, SETTLE_CYC=2).
// The reference model works per transaction: from the start level and the
// target it derives the expected level in every cycle after acceptance and
// the cycle in which done must appear.
module tb_thermo_dac_driver;

  localparam int NBITS      = 2;
  localparam int SETTLE_CYC = 2;
  localparam int NLEV       = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [NBITS-1:0] in_code;
  logic [NLEV-1:0]  therm;
  logic [NBITS-1:0] cur_code;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_fail = 0;
  int m_cur  = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  thermo_dac_driver #(
    .NBITS      (NBITS),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .therm    (therm),
    .cur_code (cur_code),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected switch pattern: lvl consecutive elements starting at the pointer.
  function automatic logic [31:0] exp_therm(input int lvl, input int ptr);
    logic [31:0] t;
    int base;
    t    = '0;
    base = 0;
`ifdef THERMO_DAC_DWA_EN
    base = ptr;
`endif
    for (int k = 0; k < lvl; k++) begin
      t[(base + k) % NLEV] = 1'b1;
    end
    return t;
  endfunction

  task automatic check_outputs(input string tag, input int lvl, input bit e_busy,
                               input bit e_done, input bit e_ready);
    chk({tag, "_cur"},   32'(cur_code), 32'(lvl));
    chk({tag, "_therm"}, 32'(therm),    exp_therm(lvl, m_ptr));
    chk({tag, "_busy"},  32'(busy),     32'(e_busy));
    chk({tag, "_done"},  32'(done),     32'(e_done));
    chk({tag, "_ready"}, 32'(in_ready), 32'(e_ready));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst   = 1'b0;
    m_cur = 0;
    m_ptr = 0;
    check_outputs("reset", 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_code  = NBITS'($urandom_range(0, 3));
      @(posedge clk); #1;
      check_outputs("idle", m_cur, 1'b0, 1'b0, 1'b1);
    end
  endtask

  // noise: 0 = in_valid low while busy, 1 = random in_valid/in_code,
  // 2 = in_valid held high with code 2. rst_at > 0 asserts reset before that edge.
  task automatic run_txn(input int code, input int noise, input int rst_at);
    int c, d, dir, n, lvl;
    c        = m_cur;
    in_valid = 1'b1;
    in_code  = NBITS'(code);
    @(posedge clk); #1;
    d   = (code > c) ? code - c : c - code;
    dir = (code > c) ? 1 : -1;
    n   = d + SETTLE_CYC;
    check_outputs("accept", c, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      case (noise)
        1: begin
          in_valid = 1'($urandom_range(0, 1));
          in_code  = NBITS'($urandom_range(0, 3));
        end
        2: begin
          in_valid = 1'b1;
          in_code  = NBITS'(2);
        end
        default: in_valid = 1'b0;
      endcase
      if (k == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst      = 1'b0;
        in_valid = 1'b0;
        m_cur    = 0;
        m_ptr    = 0;
        check_outputs("mid_rst", 0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          check_outputs("post_rst", 0, 1'b0, 1'b0, 1'b1);
        end
        return;
      end
      lvl = (k < d) ? c + dir * k : code;
      if (k == n) begin
        m_cur = code;
        m_ptr = (m_ptr + code) % NLEV;
      end
      check_outputs("ramp", lvl, k < n, k == n, k == n);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int code, noise, rst_at, d;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    do_reset();
    idle_cycles(2);

    // Directed: up-ramp 0->3, down-ramp 3->1, same code 1->1.
    run_txn(3, 0, 0);
    run_txn(1, 0, 0);
    run_txn(1, 0, 0);
    idle_cycles(1);
    // Held in_valid with code 2 during a ramp; accepted back-to-back in done cycle.
    run_txn(3, 2, 0);
    run_txn(2, 0, 0);
    // Reset in the middle of a ramp.
    run_txn(0, 0, 1);
    idle_cycles(1);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      code   = $urandom_range(0, 3);
      noise  = $urandom_range(0, 2);
      d      = (code > m_cur) ? code - m_cur : m_cur - code;
      rst_at = 0;
      if (d > 0 && $urandom_range(0, 7) == 0) rst_at = $urandom_range(1, d);
      run_txn(code, noise, rst_at);
      idle_cycles($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
